// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchronizer, mid-bit sampling from a half-bit
// start qualification, one-cycle valid / framing-error strobes.
module uart_rx #(
  parameter int unsigned CLOCKS_PER_BAUD = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic       framing_error_o
);

  localparam logic [15:0] BAUD_LAST = 16'(CLOCKS_PER_BAUD - 1);
  localparam logic [15:0] HALF_LAST = 16'((CLOCKS_PER_BAUD / 2) - 1);

  typedef enum logic [2:0] {HOLD, IDLE, START, DATA, STOP} state_t;

  logic        rx_meta_r;
  logic        rx_s;
  state_t      state_r, state_s;
  logic [15:0] baud_cnt_r, baud_cnt_s;
  logic [2:0]  bit_idx_r, bit_idx_s;
  logic [7:0]  shift_r, shift_s;
  logic [7:0]  data_s;
  logic        valid_s;
  logic        fe_s;

  // Two-flop synchronizer for the asynchronous serial line, idle-high at reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_r <= 1'b1;
      rx_s      <= 1'b1;
    end else begin
      rx_meta_r <= rx;
      rx_s      <= rx_meta_r;
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r         <= HOLD;
      baud_cnt_r      <= 16'd0;
      bit_idx_r       <= 3'd0;
      shift_r         <= 8'd0;
      data_o          <= 8'd0;
      valid_o         <= 1'b0;
      framing_error_o <= 1'b0;
    end else begin
      state_r         <= state_s;
      baud_cnt_r      <= baud_cnt_s;
      bit_idx_r       <= bit_idx_s;
      shift_r         <= shift_s;
      data_o          <= data_s;
      valid_o         <= valid_s;
      framing_error_o <= fe_s;
    end
  end

  // Next-state and strobe decode
  always_comb begin
    state_s    = state_r;
    baud_cnt_s = baud_cnt_r;
    bit_idx_s  = bit_idx_r;
    shift_s    = shift_r;
    data_s     = data_o;
    valid_s    = 1'b0;
    fe_s       = 1'b0;
    case (state_r)
      HOLD: begin
        // Wait until the synchronizer holds real post-reset samples, so its
        // reset-to-1 contents cannot fake an idle line.
        if (baud_cnt_r < 16'd2) begin
          baud_cnt_s = baud_cnt_r + 16'd1;
        end else if (rx_s) begin
          state_s    = IDLE;
          baud_cnt_s = 16'd0;
        end else begin
          baud_cnt_s = baud_cnt_r;
        end
      end
      IDLE: begin
        if (!rx_s) begin
          state_s    = START;
          baud_cnt_s = 16'd0;
        end else begin
          baud_cnt_s = 16'd0;
        end
      end
      START: begin
        if (baud_cnt_r == HALF_LAST) begin
          baud_cnt_s = 16'd0;
          bit_idx_s  = 3'd0;
          if (!rx_s) begin
            state_s = DATA;
          end else begin
            state_s = IDLE;
          end
        end else begin
          baud_cnt_s = baud_cnt_r + 16'd1;
        end
      end
      DATA: begin
        if (baud_cnt_r == BAUD_LAST) begin
          baud_cnt_s         = 16'd0;
          shift_s[bit_idx_r] = rx_s;
          bit_idx_s          = bit_idx_r + 3'd1;
          if (bit_idx_r == 3'd7) begin
            state_s = STOP;
          end else begin
            state_s = DATA;
          end
        end else begin
          baud_cnt_s = baud_cnt_r + 16'd1;
        end
      end
      STOP: begin
        if (baud_cnt_r == BAUD_LAST) begin
          baud_cnt_s = 16'd0;
          if (rx_s) begin
            data_s  = shift_r;
            valid_s = 1'b1;
            state_s = IDLE;
          end else begin
            fe_s    = 1'b1;
            state_s = HOLD;
          end
        end else begin
          baud_cnt_s = baud_cnt_r + 16'd1;
        end
      end
      default: begin
        state_s    = HOLD;
        baud_cnt_s = 16'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: two instances (8 and 32 clocks/bit) checked every cycle
// against a sample-time model of the line, plus literal expectations.
module tb_uart_rx;

  localparam int C0 = 8;
  localparam int C1 = 32;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx0, rx1;
  logic [7:0] data0, data1;
  logic       valid0, valid1, fe0, fe1;

  always #5 clk = ~clk;

  uart_rx #(.CLOCKS_PER_BAUD(C0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .rx(rx0),
    .data_o(data0), .valid_o(valid0), .framing_error_o(fe0)
  );

  uart_rx #(.CLOCKS_PER_BAUD(C1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .rx(rx1),
    .data_o(data1), .valid_o(valid1), .framing_error_o(fe1)
  );

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  int e0_rec = 0;

  // Model: mode 0 = hunting for a start edge, 1 = inside a frame, 2 = waiting for line high
  int         mode [2];
  int         e0 [2];
  int         look_from [2];
  int         pend_edge [2];
  logic       pend_fe [2];
  logic [7:0] pend_data [2];
  logic [7:0] byte_acc [2];
  logic [7:0] exp_data [2];
  logic       exp_v [2];
  logic       exp_fe [2];
  int         cper [2];

  int         vq0_edge[$];
  logic [7:0] vq0_data[$];
  logic [7:0] vq1_data[$];
  int         fecnt0 = 0;
  int         fecnt1 = 0;

  initial begin
    int d, k, cc, hh;
    logic r;
    logic got_v, got_fe;
    logic [7:0] got_d;
    cper[0] = C0;
    cper[1] = C1;
    for (int m = 0; m < 2; m++) begin
      mode[m] = 2; look_from[m] = 0; pend_edge[m] = -1; exp_data[m] = 8'd0;
      e0[m] = 0; byte_acc[m] = 8'd0; pend_fe[m] = 1'b0; pend_data[m] = 8'd0;
    end
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      for (int m = 0; m < 2; m++) begin
        r  = (m == 0) ? rx0 : rx1;
        cc = cper[m];
        hh = cc / 2;
        exp_v[m]  = 1'b0;
        exp_fe[m] = 1'b0;
        if (!rst_n) begin
          mode[m] = 2; look_from[m] = cyc + 1; pend_edge[m] = -1; exp_data[m] = 8'd0;
        end else begin
          if (pend_edge[m] == cyc) begin
            if (pend_fe[m]) exp_fe[m] = 1'b1;
            else begin
              exp_v[m] = 1'b1;
              exp_data[m] = pend_data[m];
            end
            pend_edge[m] = -1;
          end
          case (mode[m])
            0: if (cyc >= look_from[m] && !r) begin
                 e0[m] = cyc; mode[m] = 1;
               end
            1: begin
                 d = cyc - e0[m];
                 if (d == hh) begin
                   if (r) begin mode[m] = 0; look_from[m] = cyc + 1; end
                 end else if (d > hh && ((d - hh) % cc) == 0) begin
                   k = (d - hh) / cc;
                   if (k <= 8) byte_acc[m][k-1] = r;
                   else begin
                     // stop-bit sample point: strobe lands two edges later
                     pend_edge[m] = cyc + 2;
                     pend_fe[m]   = !r;
                     pend_data[m] = byte_acc[m];
                     mode[m]      = r ? 0 : 2;
                     look_from[m] = cyc + 1;
                   end
                 end
               end
            default: if (cyc >= look_from[m] && r) begin
                 mode[m] = 0; look_from[m] = cyc + 1;
               end
          endcase
        end
      end
      #1;
      for (int m = 0; m < 2; m++) begin
        got_v  = (m == 0) ? valid0 : valid1;
        got_fe = (m == 0) ? fe0 : fe1;
        got_d  = (m == 0) ? data0 : data1;
        n_cmp = n_cmp + 1;
        if (got_v !== exp_v[m] || got_fe !== exp_fe[m] || got_d !== exp_data[m]) begin
          n_bad = n_bad + 1;
          $display("FAIL cycle_check inst%0d cycle %0d: got v=%b fe=%b d=%h, want v=%b fe=%b d=%h",
                   m, cyc, got_v, got_fe, got_d, exp_v[m], exp_fe[m], exp_data[m]);
        end
      end
      if (valid0 === 1'b1) begin vq0_edge.push_back(cyc); vq0_data.push_back(data0); end
      if (valid1 === 1'b1) vq1_data.push_back(data1);
      if (fe0 === 1'b1) fecnt0 = fecnt0 + 1;
      if (fe1 === 1'b1) fecnt1 = fecnt1 + 1;
    end
  end

  task automatic chk(input string name, input int got, input int want);
    n_cmp = n_cmp + 1;
    if (got != want) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, got, got, want, want);
    end
  endtask

  task automatic drive(input int m, input logic v);
    if (m == 0) rx0 = v;
    else rx1 = v;
  endtask

  task automatic line(input int m, input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      drive(m, v);
    end
  endtask

  task automatic send(input int m, input logic [7:0] b, input int p, input logic stopv, input int nbits);
    logic [9:0] frame;
    frame = {stopv, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      for (int j = 0; j < p; j++) begin
        @(negedge clk);
        drive(m, frame[i]);
        if (i == 0 && j == 0) e0_rec = cyc + 1;
      end
    end
  endtask

  initial begin
    int n0, f0, e, p;
    logic [7:0] str [6];
    logic [7:0] b;
    str[0] = 8'h52; str[1] = 8'h31; str[2] = 8'h32;
    str[3] = 8'h33; str[4] = 8'h34; str[5] = 8'h0D;
    rst_n = 1'b0; rx0 = 1'b1; rx1 = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_data", int'(data0), 0);
    chk("reset_valid", int'(valid0), 0);
    @(negedge clk);
    rst_n = 1'b1;
    line(0, 1'b1, 20);

    // single 'R' frame, latency pinned
    n0 = vq0_edge.size();
    send(0, 8'h52, C0, 1'b1, 10);
    e = e0_rec;
    line(0, 1'b1, 12);
    chk("r_count", vq0_edge.size() - n0, 1);
    if (vq0_edge.size() > n0) begin
      chk("r_latency", vq0_edge[n0] - e, 78);
      chk("r_data", int'(vq0_data[n0]), 'h52);
    end
    chk("r_no_fe", fecnt0, 0);

    // back-to-back string
    n0 = vq0_edge.size();
    for (int i = 0; i < 6; i++) send(0, str[i], C0, 1'b1, 10);
    line(0, 1'b1, 12);
    chk("str_count", vq0_edge.size() - n0, 6);
    if (vq0_edge.size() - n0 == 6) begin
      for (int i = 0; i < 6; i++) begin
        chk("str_data", int'(vq0_data[n0+i]), int'(str[i]));
        if (i > 0) chk("str_spacing", vq0_edge[n0+i] - vq0_edge[n0+i-1], 80);
      end
    end

    // start glitch then 'A'
    n0 = vq0_edge.size();
    line(0, 1'b0, 2);
    line(0, 1'b1, 10);
    chk("glitch_silent", vq0_edge.size() - n0, 0);
    send(0, 8'h41, C0, 1'b1, 10);
    line(0, 1'b1, 12);
    chk("glitch_count", vq0_edge.size() - n0, 1);
    chk("glitch_data", int'(data0), 'h41);

    // bad stop bit, break, then recovery
    n0 = vq0_edge.size();
    f0 = fecnt0;
    send(0, 8'hA5, C0, 1'b0, 10);
    line(0, 1'b0, 30 * C0);
    chk("brk_fe_count", fecnt0 - f0, 1);
    chk("brk_no_valid", vq0_edge.size() - n0, 0);
    chk("brk_data_held", int'(data0), 'h41);
    line(0, 1'b1, 16);
    send(0, 8'h0A, C0, 1'b1, 10);
    line(0, 1'b1, 12);
    chk("brk_recover_count", vq0_edge.size() - n0, 1);
    chk("brk_recover_data", int'(data0), 'h0A);
    chk("brk_fe_total", fecnt0 - f0, 1);

    // line held low through reset release
    n0 = vq0_edge.size();
    f0 = fecnt0;
    @(negedge clk);
    rst_n = 1'b0; rx0 = 1'b0;
    line(0, 1'b0, 3);
    @(negedge clk);
    rst_n = 1'b1;
    line(0, 1'b0, 50);
    line(0, 1'b1, 16);
    chk("lowrst_silent", (vq0_edge.size() - n0) + (fecnt0 - f0), 0);
    send(0, 8'h57, C0, 1'b1, 10);
    line(0, 1'b1, 12);
    chk("lowrst_count", vq0_edge.size() - n0, 1);
    chk("lowrst_data", int'(data0), 'h57);

    // reset mid-frame after data bit 3
    n0 = vq0_edge.size();
    f0 = fecnt0;
    send(0, 8'h3C, C0, 1'b1, 5);
    @(negedge clk);
    rst_n = 1'b0;
    rx0 = 1'b1;
    #1;
    chk("midrst_data_zero", int'(data0), 0);
    line(0, 1'b1, 3);
    @(negedge clk);
    rst_n = 1'b1;
    line(0, 1'b1, 20);
    send(0, 8'h6E, C0, 1'b1, 10);
    line(0, 1'b1, 12);
    chk("midrst_count", vq0_edge.size() - n0, 1);
    chk("midrst_data", int'(data0), 'h6E);
    chk("midrst_no_fe", fecnt0 - f0, 0);

    // randomized traffic on the 8-clock instance
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        line(0, 1'b0, $urandom_range(1, 2));
        line(0, 1'b1, 8);
      end else begin
        b = 8'($urandom);
        if ($urandom_range(0, 7) == 0) begin
          send(0, b, C0, 1'b0, 10);
          line(0, 1'b0, $urandom_range(0, 20));
        end else begin
          send(0, b, C0, 1'b1, 10);
        end
        line(0, 1'b1, $urandom_range(0, 15));
      end
    end
    line(0, 1'b1, 100);

    // +3% slow source on the 32-clock instance
    n0 = vq1_data.size();
    send(1, 8'h00, 33, 1'b1, 10);
    send(1, 8'hFF, 33, 1'b1, 10);
    line(1, 1'b1, 40);
    chk("tol_count", vq1_data.size() - n0, 2);
    if (vq1_data.size() - n0 == 2) begin
      chk("tol_data0", int'(vq1_data[n0]), 'h00);
      chk("tol_data1", int'(vq1_data[n0+1]), 'hFF);
    end
    chk("tol_no_fe", fecnt1, 0);
    for (int i = 0; i < 8; i++) begin
      p = $urandom_range(31, 33);
      send(1, 8'($urandom), p, 1'b1, 10);
      line(1, 1'b1, $urandom_range(0, 10));
    end
    line(1, 1'b1, 60);
    chk("tol_rand_count", vq1_data.size() - n0, 10);
    chk("tol_rand_no_fe", fecnt1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
